// File: rtl/sw_button_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : sw_button_ctrl
//  Description : Stopwatch front-end. Synchronises and debounces the raw
//                start/stop and clear buttons, turns accepted presses into
//                single-cycle events and runs the IDLE/RUNNING/PAUSED state
//                machine that drives the time-count stage.
//                Optional lap button and display-hold output are built when
//                the macro SW_BUTTON_LAP_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module sw_button_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_start_i,
    input  logic       btn_clear_i,
`ifdef SW_BUTTON_LAP_EN
    input  logic       btn_lap_i,
    output logic       lap_hold_o,
`endif
    output logic       run_o,
    output logic       clear_o,
    output logic [1:0] state_o
);

`ifdef SW_BUTTON_LAP_EN
    localparam int c_num_btn = 3;
`else
    localparam int c_num_btn = 2;
`endif

    // Terminal count: a level must hold this many further cycles to be accepted.
    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_RUNNING = 2'b01,
        ST_PAUSED  = 2'b10
    } state_t;

    logic [c_num_btn-1:0] w_raw;
    logic [c_num_btn-1:0] w_press;

    logic   w_start_evt;
    logic   w_clear_evt;
    state_t r_state;
    state_t w_state_next;
    logic   w_clear_next;
    logic   r_run;
    logic   r_clear;

`ifdef SW_BUTTON_LAP_EN
    assign w_raw = {btn_lap_i, btn_clear_i, btn_start_i};
`else
    assign w_raw = {btn_clear_i, btn_start_i};
`endif

    // One identical synchroniser / debouncer / edge detector per button.
    generate
        for (genvar gi = 0; gi < c_num_btn; gi++) begin : g_btn
            logic             r_sync1;
            logic             r_sync2;
            logic             r_stable;
            logic             r_stable_d;
            logic [CNT_W-1:0] r_cnt;

            // Synchronise, then accept a new level only after it holds long enough.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_sync1    <= 1'b0;
                    r_sync2    <= 1'b0;
                    r_stable   <= 1'b0;
                    r_stable_d <= 1'b0;
                    r_cnt      <= '0;
                end else begin
                    r_sync1    <= w_raw[gi];
                    r_sync2    <= r_sync1;
                    r_stable_d <= r_stable;
                    if (r_sync2 == r_stable) begin
                        r_cnt <= '0;
                    end else if (r_cnt == c_cnt_last) begin
                        r_stable <= r_sync2;
                        r_cnt    <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
            end

            // Rising edge of the debounced level; releases produce nothing.
            assign w_press[gi] = r_stable & ~r_stable_d;
        end
    endgenerate

    assign w_start_evt = w_press[0];
    assign w_clear_evt = w_press[1];

    // Next-state decode: clear outranks start except in RUNNING, where clear is ignored.
    always_comb begin
        w_state_next = r_state;
        w_clear_next = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_clear_evt) begin
                    w_clear_next = 1'b1;
                end else if (w_start_evt) begin
                    w_state_next = ST_RUNNING;
                end
            end
            ST_RUNNING: begin
                if (w_start_evt) begin
                    w_state_next = ST_PAUSED;
                end
            end
            ST_PAUSED: begin
                if (w_clear_evt) begin
                    w_state_next = ST_IDLE;
                    w_clear_next = 1'b1;
                end else if (w_start_evt) begin
                    w_state_next = ST_RUNNING;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs; run follows the next state so it moves with state_o.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_run   <= 1'b0;
            r_clear <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_run   <= (w_state_next == ST_RUNNING);
            r_clear <= w_clear_next;
        end
    end

    assign state_o = r_state;
    assign run_o   = r_run;
    assign clear_o = r_clear;

`ifdef SW_BUTTON_LAP_EN
    logic w_lap_evt;
    logic w_hold_next;
    logic r_lap_hold;

    assign w_lap_evt = w_press[2];

    // Hold only survives while staying in RUNNING; lap toggles it there and nowhere else.
    always_comb begin
        w_hold_next = r_lap_hold;
        if (w_state_next != ST_RUNNING) begin
            w_hold_next = 1'b0;
        end else if ((r_state == ST_RUNNING) && w_lap_evt) begin
            w_hold_next = ~r_lap_hold;
        end
    end

    // Display-hold register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_lap_hold <= 1'b0;
        end else begin
            r_lap_hold <= w_hold_next;
        end
    end

    assign lap_hold_o = r_lap_hold;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sw_button_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sw_button_ctrl
//  Description : Table-driven bench for sw_button_ctrl with DEBOUNCE_CYCLES=4,
//                plus hand-written held-button and mid-operation reset
//                sequences. Lap rows are included when SW_BUTTON_LAP_EN is set.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sw_button_ctrl;

    logic       clk;
    logic       reset;
    logic       btn_start_i;
    logic       btn_clear_i;
    logic       btn_lap;
    logic       run_o;
    logic       clear_o;
    logic [1:0] state_o;
`ifdef SW_BUTTON_LAP_EN
    logic       lap_hold_o;
`endif

    sw_button_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .CNT_W          (3)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .btn_start_i(btn_start_i),
        .btn_clear_i(btn_clear_i),
`ifdef SW_BUTTON_LAP_EN
        .btn_lap_i  (btn_lap),
        .lap_hold_o (lap_hold_o),
`endif
        .run_o      (run_o),
        .clear_o    (clear_o),
        .state_o    (state_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       start;
        logic       clear;
        logic       lap;
        logic [1:0] st;
        logic       run;
        logic       clr;
        logic       hold;
    } vec_t;

    vec_t vecs[512];
    int   nvec   = 0;
    int   n_chk  = 0;
    int   n_pass = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic add(input logic s, input logic c, input logic l, input logic [1:0] st,
                       input logic run, input logic clr, input logic hold);
        vecs[nvec] = '{s, c, l, st, run, clr, hold};
        nvec++;
    endtask

    // Buttons high for rows 0..7, low for 8..15. With the press first sampled
    // at row 0, the outputs take their new values at row 6.
    task automatic add_press(input logic s, input logic c, input logic l,
                             input logic [1:0] st0, input logic run0, input logic hold0,
                             input logic [1:0] st1, input logic run1, input logic pulse,
                             input logic hold1);
        for (int r = 0; r < 16; r++) begin
            if (r < 6)       add(r < 8 ? s : 1'b0, r < 8 ? c : 1'b0, r < 8 ? l : 1'b0, st0, run0, 1'b0, hold0);
            else if (r == 6) add(s, c, l, st1, run1, pulse, hold1);
            else             add(r < 8 ? s : 1'b0, r < 8 ? c : 1'b0, r < 8 ? l : 1'b0, st1, run1, 1'b0, hold1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int changes;
        int pulses;
        logic [1:0] prev;

        clk         = 1'b0;
        reset       = 1'b0;
        btn_start_i = 1'b0;
        btn_clear_i = 1'b0;
        btn_lap     = 1'b0;

        // Reset asserted between edges must clear outputs immediately.
        #2 reset = 1'b1;
        #1;
        chk("rst_async_state", state_o, 0);
        chk("rst_async_run",   run_o,   0);
        chk("rst_async_clear", clear_o, 0);
        repeat (3) @(posedge clk);
        @(negedge clk) reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rel_state", state_o, 0);
        chk("rst_rel_run",   run_o,   0);
        chk("rst_rel_clear", clear_o, 0);

        // Start held 10 cycles from IDLE: RUNNING at row 6, release ignored.
        for (int r = 0; r < 18; r++)
            add(r < 10, 1'b0, 1'b0, (r < 6) ? 2'b00 : 2'b01, r >= 6, 1'b0, 1'b0);

        // Bouncy start (1,1,0, then 1 x8): last rise at row 3, PAUSED at row 9.
        for (int r = 0; r < 19; r++)
            add((r != 2) && (r < 11), 1'b0, 1'b0, (r < 9) ? 2'b01 : 2'b10, r < 9, 1'b0, 1'b0);

        add_press(1, 0, 0, 2'b10, 0, 0, 2'b01, 1, 0, 0);   // PAUSED  -> RUNNING
        add_press(1, 0, 0, 2'b01, 1, 0, 2'b10, 0, 0, 0);   // RUNNING -> PAUSED
        add_press(0, 1, 0, 2'b10, 0, 0, 2'b00, 0, 1, 0);   // PAUSED  -> IDLE, pulse
        add_press(0, 1, 0, 2'b00, 0, 0, 2'b00, 0, 1, 0);   // IDLE clear, pulse
        add_press(1, 0, 0, 2'b00, 0, 0, 2'b01, 1, 0, 0);   // IDLE -> RUNNING
        add_press(0, 1, 0, 2'b01, 1, 0, 2'b01, 1, 0, 0);   // clear ignored in RUNNING
        add_press(1, 1, 0, 2'b01, 1, 0, 2'b10, 0, 0, 0);   // both in RUNNING: start wins
        add_press(1, 1, 0, 2'b10, 0, 0, 2'b00, 0, 1, 0);   // both in PAUSED: clear wins
`ifdef SW_BUTTON_LAP_EN
        add_press(1, 0, 0, 2'b00, 0, 0, 2'b01, 1, 0, 0);
        add_press(0, 0, 1, 2'b01, 1, 0, 2'b01, 1, 0, 1);   // lap -> hold
        add_press(0, 0, 1, 2'b01, 1, 1, 2'b01, 1, 0, 0);   // lap -> release hold
        add_press(0, 0, 1, 2'b01, 1, 0, 2'b01, 1, 0, 1);
        add_press(1, 0, 0, 2'b01, 1, 1, 2'b10, 0, 0, 0);   // stop clears hold
        add_press(0, 0, 1, 2'b10, 0, 0, 2'b10, 0, 0, 0);   // lap ignored in PAUSED
        add_press(0, 1, 0, 2'b10, 0, 0, 2'b00, 0, 1, 0);
`endif

        for (int i = 0; i < nvec; i++) begin
            @(negedge clk);
            btn_start_i = vecs[i].start;
            btn_clear_i = vecs[i].clear;
            btn_lap     = vecs[i].lap;
            @(posedge clk);
            #1;
            chk($sformatf("row%0d_state", i), state_o, vecs[i].st);
            chk($sformatf("row%0d_run",   i), run_o,   vecs[i].run);
            chk($sformatf("row%0d_clear", i), clear_o, vecs[i].clr);
`ifdef SW_BUTTON_LAP_EN
            chk($sformatf("row%0d_hold",  i), lap_hold_o, vecs[i].hold);
`endif
        end

        // Long hold: exactly one transition, no clear pulse.
        changes = 0;
        pulses  = 0;
        prev    = state_o;
        @(negedge clk) btn_start_i = 1'b1;
        repeat (30) begin
            @(posedge clk);
            #1;
            if (state_o != prev) changes++;
            prev = state_o;
            if (clear_o) pulses++;
        end
        chk("held_changes", changes, 1);
        chk("held_state",   state_o, 1);
        chk("held_run",     run_o,   1);
        chk("held_pulses",  pulses,  0);
        @(negedge clk) btn_start_i = 1'b0;
        repeat (10) @(posedge clk);

        // Reset mid-debounce while RUNNING: everything aborts, the press is lost.
        @(negedge clk) btn_start_i = 1'b1;
        repeat (3) @(posedge clk);
        #3 reset = 1'b1;
        #1;
        chk("midrst_state", state_o, 0);
        chk("midrst_run",   run_o,   0);
        chk("midrst_clear", clear_o, 0);
        @(negedge clk) btn_start_i = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("postrst_state", state_o, 0);
        chk("postrst_run",   run_o,   0);
        chk("postrst_clear", clear_o, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sw_button_ctrl.md
Name: sw_button_ctrl

Overview:
Front-end control stage of the stopwatch. Synchronises and debounces the raw start/stop and clear push-buttons, and turns them into single-cycle press events. A small run-state machine then drives the enable and synchronous-clear inputs of the downstream time-count register stage. All outputs are registered.

Parameters:
DEBOUNCE_CYCLES, 1000000, consecutive clk cycles a synchronised button level must hold before it is accepted (minimum 2)
CNT_W, 20, debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  asynchronous, active-high; clears all state
btn_start_i  input  1  raw start/stop button, asynchronous to clk, active-high
btn_clear_i  input  1  raw clear button, asynchronous to clk, active-high
run_o  output  1  count enable to the time-count stage; high only in RUNNING
clear_o  output  1  one-cycle synchronous clear pulse to the time-count stage
state_o  output  2  current state: 00 IDLE, 01 RUNNING, 10 PAUSED (11 never driven)

Behaviour:
- Reset (async, active-high), for its whole assertion: sync flops 0, stable levels 0, counters 0, state IDLE, run_o 0, clear_o 0, state_o 00. Release is clean; first update on the next clk edge.
- Per-button pipeline (identical for start and clear):
  - Two-flop synchroniser sync1 -> sync2.
  - Debounce: if sync2 == stable, cnt <= 0.
  - Else if cnt == DEBOUNCE_CYCLES-1, stable <= sync2 and cnt <= 0.
  - Else cnt <= cnt+1.
  - Any glitch back to the stable level restarts the count from 0.
- Press event = stable high AND registered copy of stable low. It is high for exactly one cycle per accepted press. Releases generate no event.
- Latency: call the first edge that samples raw high edge 0. Then stable rises at edge DEBOUNCE_CYCLES+1, and state/run_o/clear_o update at edge DEBOUNCE_CYCLES+2. This assumes raw is held high through edge DEBOUNCE_CYCLES-1.
- FSM on press events:
  - IDLE: start -> RUNNING. Clear -> stays IDLE, clear_o pulses.
  - RUNNING: start -> PAUSED. Clear is ignored (no pulse).
  - PAUSED: start -> RUNNING. Clear -> IDLE, clear_o pulses.
  - Simultaneous start+clear in IDLE or PAUSED: clear wins, giving IDLE with a clear_o pulse; start is discarded.
  - Simultaneous start+clear in RUNNING: start is processed, giving PAUSED; clear is discarded.
- run_o = (next state == RUNNING), registered. It changes on the same edge as state_o.
- clear_o is high for exactly one clk cycle per accepted clear. It never asserts two cycles back to back.
- A held button generates only one event, however long it is held.
- Reset mid-operation (mid-debounce or in any state) aborts everything; a press in progress is lost.
- The counter never exceeds DEBOUNCE_CYCLES-1; there is no wrap.

Optional Feature:
Macro: SW_BUTTON_LAP_EN
- Defined:
  - Adds port btn_lap_i (input, 1, raw lap button), debounced with the same pipeline.
  - Adds port lap_hold_o (output, 1, freezes the display latch; counting continues).
  - Lap press in RUNNING toggles lap_hold_o.
  - Lap press in PAUSED or IDLE is ignored.
  - lap_hold_o is forced 0 on any transition into IDLE and on reset.
  - lap_hold_o is also cleared by start/stop when it leaves RUNNING.
  - Lap has lowest priority when simultaneous with start or clear.
- Undefined: the lap ports and logic are absent; behaviour is otherwise identical.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4.
1. Reset asserted mid-cycle, then released -> run_o=0, clear_o=0, state_o=00 immediately on assertion, and held after release.
2. btn_start_i high 10 cycles from IDLE -> state_o=01 and run_o=1 exactly at edge 6; no further change while held; release produces no event.
3. btn_start_i bounces (high 2 cycles, low 1, high 8) -> single transition to RUNNING, 6 edges after the last low-to-high sample; exactly one event.
4. Sequence start, start, clear (each held 8 cycles with gaps) -> 01 -> 10 -> 00; clear_o high exactly 1 cycle on the final transition; run_o low from the second press on.
5. In RUNNING, press clear alone -> no clear_o, state stays 01. Then start and clear pressed in the same cycle -> state 10, no clear_o. Then both pressed again from PAUSED -> state 00 with one clear_o pulse.
6. With SW_BUTTON_LAP_EN: in RUNNING, press lap twice -> lap_hold_o 1 then 0, run_o stays 1. Press lap, then start -> state 10, lap_hold_o 0. Lap in PAUSED -> no change.
